cla_shift_add_mult_8bit: RTL and testbench
==========================================

// Module: cla_shift_add_mult_8bit
// PURPOSE
//  Sequential shift-and-add multiplier that drives the existing 8-bit CLA adder/subtractor (fa_cla_8bit_v2).
//  Holds the operands, presents one partial-product add per clock to the external adder, and accumulates
//  the WIDTH-bit sum it returns. Gives the datapath a WIDTH x WIDTH -> 2*WIDTH multiply with no second adder.
// PARAMETERS
//  WIDTH   8   operand width; must match the attached CLA adder width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        request; sampled only in IDLE/DONE
//  multiplicand   in   WIDTH    operand M, captured on accepted start
//  multiplier     in   WIDTH    operand Q, captured on accepted start
//  busy           out  1        high in RUN
//  done           out  1        one-cycle pulse on the DONE entry cycle
//  product        out  2*WIDTH  {A,Q} result; held stable from done until next accepted start
//  add_a          out  WIDTH    to adder a: accumulator A
//  add_b          out  WIDTH    to adder b: Q[0] ? M : 0
//  add_sub        out  1        to adder sub: 0, except signed final step (see CONFIGURATION)
//  add_c_in       out  1        to adder c_in: constant 0
//  add_sum        in   WIDTH    from adder sum (combinational, same cycle)
//  add_c_out      in   WIDTH+1  from adder c_out chain; [WIDTH] carry-out, [WIDTH-1] into MSB
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, A=0, Q=0, M=0, C=0, cnt=0; busy=0, done=0, product=0.
//    Reset mid-RUN aborts immediately; no done pulse; a fresh start is needed.
//  - States: IDLE -(start)-> RUN -(cnt==WIDTH-1 step)-> DONE -(next clk)-> IDLE.
//    start sampled in DONE is accepted as in IDLE (back-to-back ops; DONE->RUN).
//  - Accept: M<=multiplicand, Q<=multiplier, A<=0, C<=0, cnt<=0, state<=RUN.
//  - start while busy: ignored; operands not re-captured.
//  - RUN step (one per clk, cnt=0..WIDTH-1):
//      {C,A} <= Q[0] ? {add_c_out[WIDTH],add_sum} : {1'b0,A}; then {C,A,Q} shifted right 1, C<=0.
//      Implemented as a single registered update: A<={sel_c,sel_sum[WIDTH-1:1]}, Q<={sel_sum[0],Q[WIDTH-1:1]}.
//  - Latency: start accepted at edge k; done=1 during cycle k+WIDTH+1 (WIDTH RUN cycles, then DONE).
//  - product = {A,Q}; updates only in RUN; fixed from DONE onwards.
//  - Arithmetic is modulo 2^(2*WIDTH); unsigned result is exact, no overflow possible.
//  - add_a/add_b/add_sub driven combinationally from registers; values outside RUN are don't-care
//    but must be stable (no X), i.e. derived from reset registers.
// CONFIGURATION
//  MULT_SIGNED_EN defined: operands are two's complement, product is signed 2*WIDTH.
//    Steps cnt<WIDTH-1: add M when Q[0]; shifted-in MSB = sel_sum[WIDTH-1] ^ ovf, ovf =
//    add_c_out[WIDTH]^add_c_out[WIDTH-1] when adding, else A[WIDTH-1] (arithmetic shift).
//    Step cnt==WIDTH-1: add_sub=1 (subtract M) when Q[0]; same sign-correct shift.
//  MULT_SIGNED_EN undefined: unsigned only; add_sub tied 0; ovf logic absent.
// TESTING
//  1. unsigned: M=0x11, Q=0x11, start 1 clk -> done at start+9, product=0x0121, busy high 8 clks.
//  2. unsigned: M=0xAA, Q=0x55 -> product=0x3872; M=0xFF, Q=0xFF -> 0xFE01; M=0xFF, Q=0x01 -> 0x00FF.
//  3. start held high throughout op 1 with operands changed mid-RUN -> result still 0x0121;
//     start high in DONE -> next op begins, done pulses again WIDTH+1 clks later.
//  4. rst_n low at RUN cycle 4 -> busy=0, done=0, product=0 immediately; no done pulse afterwards.
//  5. MULT_SIGNED_EN: 0xFF*0x01 -> 0xFFFF; 0x80*0x80 -> 0x4000; 0x7F*0x80 -> 0xC080; 0x05*0xFD -> 0xFFF1.
//  6. bench instantiates fa_cla_8bit_v2 on the add_* ports; checks add_c_in==0 always and
//     add_sub==0 in all unsigned runs.

Source files
------------

// File: rtl/cla_shift_add_mult_8bit.sv
// rtl/cla_shift_add_mult_8bit.sv - shift-and-add multiplier sequencing an external CLA adder; MULT_SIGNED_EN selects signed mode
module cla_shift_add_mult_8bit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_sub,
    output logic               add_c_in,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic [WIDTH:0]     add_c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;

    logic             last_step;
    logic             add_en;
    logic [WIDTH-1:0] sel_sum;
    logic             sel_c;

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign add_en    = q_reg[0];
    assign sel_sum   = add_en ? add_sum : a_reg;

    assign add_a    = a_reg;
    assign add_b    = add_en ? m_reg : '0;
    assign add_c_in = 1'b0;
    assign product  = {a_reg, q_reg};

`ifdef MULT_SIGNED_EN
    // True sign of the 9-bit signed sum recovered from the overflow flag;
    // without an add the shift is arithmetic.
    logic ovf;
    logic unused_c_out;
    assign ovf          = add_c_out[WIDTH] ^ add_c_out[WIDTH-1];
    assign sel_c        = add_en ? (add_sum[WIDTH-1] ^ ovf) : a_reg[WIDTH-1];
    assign add_sub      = (state == S_RUN) && last_step && add_en;
    assign unused_c_out = ^add_c_out[WIDTH-2:0];
`else
    logic unused_c_out;
    assign sel_c        = add_en & add_c_out[WIDTH];
    assign add_sub      = 1'b0;
    assign unused_c_out = ^add_c_out[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Add and right-shift of {C,A,Q} folded into one update.
                    a_reg <= {sel_c, sel_sum[WIDTH-1:1]};
                    q_reg <= {sel_sum[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_shift_add_mult_8bit.sv
// tb/tb_cla_shift_add_mult_8bit.sv - self-checking bench for cla_shift_add_mult_8bit with a behavioural CLA adder
module tb_cla_shift_add_mult_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_sub;
    logic        add_c_in;
    logic [7:0]  add_sum;
    logic [8:0]  add_c_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_shift_add_mult_8bit #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sub      (add_sub),
        .add_c_in     (add_c_in),
        .add_sum      (add_sum),
        .add_c_out    (add_c_out)
    );

    // Adder/subtractor: sub inverts b and forces a carry-in; c_out[i] is the carry into bit i.
    logic [7:0] b_eff;
    logic       c0;
    logic [8:0] full_sum;
    logic [7:0] low_sum;
    always_comb begin
        b_eff    = add_b ^ {8{add_sub}};
        c0       = add_c_in | add_sub;
        full_sum = {1'b0, add_a} + {1'b0, b_eff} + {8'd0, c0};
        low_sum  = {1'b0, add_a[6:0]} + {1'b0, b_eff[6:0]} + {7'd0, c0};
        add_sum  = full_sum[7:0];
        add_c_out = {full_sum[8], low_sum[7], 7'd0};
        add_c_out[0] = c0;
    end

    function automatic logic [15:0] ref_mult(input logic [7:0] m, input logic [7:0] q);
`ifdef MULT_SIGNED_EN
        int sm;
        int sq;
        sm = int'($signed(m));
        sq = int'($signed(q));
        return 16'(sm * sq);
`else
        return 16'(int'(m) * int'(q));
`endif
    endfunction

    task automatic do_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp, input string tag);
        int cyc;
        int busy_cnt;
        int side_bad;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        side_bad = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (add_c_in !== 1'b0) side_bad++;
`ifndef MULT_SIGNED_EN
            if (add_sub !== 1'b0) side_bad++;
`endif
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || cyc != 9) begin
            bad++;
            $display("FAIL %s latency: done=%b cycle=%0d required done=1 cycle=9", tag, done, cyc);
        end
        total++;
        if (product !== exp) begin
            bad++;
            $display("FAIL %s product: got %h required %h (m=%h q=%h)", tag, product, exp, m, q);
        end
        total++;
        if (busy_cnt != 8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: high %0d cycles, busy at done=%b, required 8 and 0", tag, busy_cnt, busy);
        end
        total++;
        if (side_bad != 0) begin
            bad++;
            $display("FAIL %s adder controls: %0d bad add_c_in/add_sub samples, required 0", tag, side_bad);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || product !== exp) begin
            bad++;
            $display("FAIL %s hold: done=%b product=%h required done=0 product=%h", tag, done, product, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = 8'h5A;
        multiplier   = 8'hC3;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || add_c_in !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b product=%h c_in=%b required 0 0 0000 0", busy, done, product, add_c_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
`ifdef MULT_SIGNED_EN
        do_op(8'hFF, 8'h01, 16'hFFFF, "s_ff_01");
        do_op(8'h80, 8'h80, 16'h4000, "s_80_80");
        do_op(8'h7F, 8'h80, 16'hC080, "s_7f_80");
        do_op(8'h05, 8'hFD, 16'hFFF1, "s_05_fd");
        do_op(8'h11, 8'h11, 16'h0121, "s_11_11");
`else
        do_op(8'h11, 8'h11, 16'h0121, "u_11_11");
        do_op(8'hAA, 8'h55, 16'h3872, "u_aa_55");
        do_op(8'hFF, 8'hFF, 16'hFE01, "u_ff_ff");
        do_op(8'hFF, 8'h01, 16'h00FF, "u_ff_01");
        do_op(8'h00, 8'hFF, 16'h0000, "u_00_ff");
`endif
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [7:0] q;
        for (int i = 0; i < 24; i++) begin
            m = 8'($urandom);
            q = 8'($urandom);
            do_op(m, q, ref_mult(m, q), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0]  m2;
        logic [7:0]  q2;
        logic [15:0] e2;
        @(negedge clk);
        multiplicand = 8'h11;
        multiplier   = 8'h11;
        start        = 1'b1;
        @(negedge clk);
        cyc = 1;
        m2 = 8'($urandom);
        q2 = 8'($urandom);
        multiplicand = m2;
        multiplier   = q2;
        e2 = ref_mult(m2, q2);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || cyc != 9 || product !== 16'h0121) begin
            bad++;
            $display("FAIL b2b first: done=%b cycle=%0d product=%h required 1 9 0121", done, cyc, product);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b restart: busy=%b done=%b required busy=1 done=0", busy, done);
        end
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || cyc != 9 || product !== e2) begin
            bad++;
            $display("FAIL b2b second: done=%b cycle=%0d product=%h required 1 9 %h", done, cyc, product, e2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL mid_reset aftermath: %0d cycles with busy/done high, required 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        do_op(8'h11, 8'h11, 16'h0121, "post_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
